// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the device clock, issues a request-to-send,
// then shifts one byte out on device-generated clock edges and reports ack, nack or timeout.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int RTS_CYCLES     = 50,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_err,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe
);

   localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
   localparam int RTS_W = $clog2(RTS_CYCLES) + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;

   localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
   localparam logic [RTS_W-1:0] RTS_LAST = RTS_W'(RTS_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      INHIBIT,
      RTS,
      SHIFT,
      ACK,
      WAIT_IDLE
   } state_t;

   state_t           state_q, state_d;
   logic             clk_s1_q, clk_s2_q, clk_prev_q;
   logic             data_s1_q, data_s2_q;
   logic [9:0]       shift_q, shift_d;
   logic [3:0]       edge_q, edge_d;
   logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
   logic [RTS_W-1:0] rts_cnt_q, rts_cnt_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             ready_q, ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             clk_oe_q, clk_oe_d;
   logic             data_oe_q, data_oe_d;

   logic             fall;
   logic             accept;
   logic             shift_edge;
   logic             got_ack;
   logic             got_nack;
   logic             timed_out;

   assign fall   = clk_prev_q & ~clk_s2_q;
   assign accept = tx_valid & ready_q;

   always_ff @(posedge clk) begin
      if (!reset_) begin
         state_q    <= IDLE;
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         clk_prev_q <= 1'b1;
         data_s1_q  <= 1'b1;
         data_s2_q  <= 1'b1;
         shift_q    <= '0;
         edge_q     <= '0;
         inh_cnt_q  <= '0;
         rts_cnt_q  <= '0;
         to_cnt_q   <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         clk_oe_q   <= 1'b0;
         data_oe_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         clk_s1_q   <= ps2_clk_in;
         clk_s2_q   <= clk_s1_q;
         clk_prev_q <= clk_s2_q;
         data_s1_q  <= ps2_data_in;
         data_s2_q  <= data_s1_q;
         shift_q    <= shift_d;
         edge_q     <= edge_d;
         inh_cnt_q  <= inh_cnt_d;
         rts_cnt_q  <= rts_cnt_d;
         to_cnt_q   <= to_cnt_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         clk_oe_q   <= clk_oe_d;
         data_oe_q  <= data_oe_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      edge_d     = edge_q;
      inh_cnt_d  = inh_cnt_q;
      rts_cnt_d  = rts_cnt_q;
      to_cnt_d   = to_cnt_q;
      shift_edge = 1'b0;
      got_ack    = 1'b0;
      got_nack   = 1'b0;
      timed_out  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = INHIBIT;
               shift_d   = {1'b1, ~^tx_data, tx_data};
               inh_cnt_d = '0;
            end
         end
         INHIBIT: begin
            if (inh_cnt_q == INH_LAST) begin
               state_d   = RTS;
               rts_cnt_d = '0;
            end else begin
               inh_cnt_d = inh_cnt_q + 1'b1;
            end
         end
         RTS: begin
            if (rts_cnt_q == RTS_LAST) begin
               state_d  = SHIFT;
               edge_d   = '0;
               to_cnt_d = '0;
            end else begin
               rts_cnt_d = rts_cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (fall) begin
               to_cnt_d   = '0;
               shift_d    = {1'b0, shift_q[9:1]};
               edge_d     = edge_q + 4'd1;
               shift_edge = 1'b1;
               if (edge_q == 4'd9) state_d = ACK;
            end else if (to_cnt_q == TO_LAST) begin
               timed_out = 1'b1;
               state_d   = WAIT_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         ACK: begin
            if (fall) begin
               state_d  = WAIT_IDLE;
               got_ack  = ~data_s2_q;
               got_nack = data_s2_q;
            end else if (to_cnt_q == TO_LAST) begin
               timed_out = 1'b1;
               state_d   = WAIT_IDLE;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         WAIT_IDLE: begin
            if (clk_s2_q && data_s2_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_comb begin
      ready_d  = (state_d == IDLE);
      busy_d   = (state_d != IDLE);
      done_d   = got_ack;
      err_d    = got_nack | timed_out;
      clk_oe_d = (state_d == INHIBIT) || (state_d == RTS);
      case (state_d)
         RTS:     data_oe_d = 1'b1;
         SHIFT:   data_oe_d = shift_edge ? ~shift_q[0] : data_oe_q;
         default: data_oe_d = 1'b0;
      endcase
   end

   assign tx_ready    = ready_q;
   assign tx_busy     = busy_q;
   assign tx_done     = done_q;
   assign tx_err      = err_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 line model and a simple
// keyboard model that clocks frames and returns ack or nack.
module tb_ps2_host_tx;

   localparam int INH  = 10;
   localparam int RTS  = 4;
   localparam int TMO  = 200;
   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready, tx_busy, tx_done, tx_err;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       clk_line, data_line;

   int n_checks = 0;
   int n_fail = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int overlap_cnt = 0;

   assign clk_line  = ~(ps2_clk_oe | dev_clk_low);
   assign data_line = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .RTS_CYCLES(RTS),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk),
      .reset_(reset_),
      .tx_data(tx_data),
      .tx_valid(tx_valid),
      .tx_ready(tx_ready),
      .tx_busy(tx_busy),
      .tx_done(tx_done),
      .tx_err(tx_err),
      .ps2_clk_in(clk_line),
      .ps2_data_in(data_line),
      .ps2_clk_oe(ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe)
   );

   always #5 clk = ~clk;

   // Pulse tally observed on the falling clock edge.
   always @(negedge clk) begin
      if (tx_done === 1'b1) done_cnt++;
      if (tx_err === 1'b1) err_cnt++;
      if (tx_done === 1'b1 && tx_err === 1'b1) overlap_cnt++;
   end

   initial begin
      #(10 * 60000);
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic start_tx(input logic [7:0] b);
      int g;
      g = 0;
      @(negedge clk);
      while (tx_ready !== 1'b1 && g < 500) begin
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (tx_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL start_ready: tx_ready=%b required 1", tx_ready);
      end
      tx_data  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_rts();
      int g;
      g = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && g < 1000) begin
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1)) begin
         n_fail++;
         $display("[TB] FAIL wait_rts: clk_oe=%b data_oe=%b required 0/1", ps2_clk_oe, ps2_data_oe);
      end
   endtask

   task automatic wait_ready();
      int g;
      g = 0;
      while (tx_ready !== 1'b1 && g < 1000) begin
         @(negedge clk);
         g++;
      end
      n_checks++;
      if (tx_ready !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL wait_ready: tx_ready=%b required 1", tx_ready);
      end
   endtask

   // One device clock pulse; the device samples data just before it releases the clock.
   task automatic dev_edge(output logic sampled);
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      sampled = data_line;
      dev_clk_low = 1'b0;
   endtask

   task automatic dev_bits(input int n, output logic [9:0] bits);
      logic s;
      bits = '0;
      for (int e = 0; e < n; e++) begin
         dev_edge(s);
         bits[e] = s;
      end
   endtask

   task automatic dev_ack(input logic ack);
      logic s;
      dev_data_low = ack;
      dev_edge(s);
      repeat (HALF) @(negedge clk);
      dev_data_low = 1'b0;
   endtask

   task automatic test_reset();
      reset_ = 1'b0;
      repeat (3) @(negedge clk);
      n_checks += 6;
      if (tx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ready: got %b required 0", tx_ready); end
      if (tx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b required 0", tx_busy); end
      if (tx_done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done: got %b required 0", tx_done); end
      if (tx_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b required 0", tx_err); end
      if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_clk_oe: got %b required 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_data_oe: got %b required 0", ps2_data_oe); end
      reset_ = 1'b1;
      @(negedge clk);
      n_checks += 2;
      if (tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_ready: got %b required 1", tx_ready); end
      if (tx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_release_busy: got %b required 0", tx_busy); end
   endtask

   task automatic test_inhibit_rts();
      logic [9:0] bits;
      logic       exp_clk, exp_data;
      int         d0;
      d0 = done_cnt;
      @(negedge clk);
      tx_data  = 8'h12;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         if (k > 1) @(negedge clk);
         exp_clk  = (k <= 14);
         exp_data = (k >= 11);
         n_checks += 2;
         if (ps2_clk_oe !== exp_clk) begin
            n_fail++;
            $display("[TB] FAIL timing_clk_oe cycle %0d: got %b required %b", k, ps2_clk_oe, exp_clk);
         end
         if (ps2_data_oe !== exp_data) begin
            n_fail++;
            $display("[TB] FAIL timing_data_oe cycle %0d: got %b required %b", k, ps2_data_oe, exp_data);
         end
      end
      dev_bits(10, bits);
      n_checks++;
      if (bits !== 10'h312) begin
         n_fail++;
         $display("[TB] FAIL timing_frame_bits: got %h required 312", bits);
      end
      dev_ack(1'b1);
      wait_ready();
      @(negedge clk);
      n_checks++;
      if (done_cnt - d0 !== 1) begin
         n_fail++;
         $display("[TB] FAIL timing_done_count: got %0d required 1", done_cnt - d0);
      end
   endtask

   task automatic test_ack_ed();
      logic [9:0] bits;
      int         d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'hED);
      wait_rts();
      n_checks += 2;
      if (tx_busy !== 1'b1) begin n_fail++; $display("[TB] FAIL ack_busy: got %b required 1", tx_busy); end
      if (tx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL ack_ready_low: got %b required 0", tx_ready); end
      dev_bits(10, bits);
      n_checks += 2;
      if (bits[8:0] !== 9'h1ED) begin
         n_fail++;
         $display("[TB] FAIL ack_data_bits: got %h required 1ed", bits[8:0]);
      end
      if (bits[9] !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ack_stop_released: got %b required 1", bits[9]);
      end
      dev_ack(1'b1);
      wait_ready();
      @(negedge clk);
      n_checks += 2;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL ack_done_count: got %0d required 1", done_cnt - d0); end
      if (err_cnt - e0 !== 0) begin n_fail++; $display("[TB] FAIL ack_err_count: got %0d required 0", err_cnt - e0); end
   endtask

   task automatic test_nack_ff();
      logic [9:0] bits;
      int         d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'hFF);
      wait_rts();
      dev_bits(10, bits);
      n_checks++;
      if (bits !== 10'h3FF) begin
         n_fail++;
         $display("[TB] FAIL nack_frame_bits: got %h required 3ff", bits);
      end
      dev_ack(1'b0);
      wait_ready();
      @(negedge clk);
      n_checks += 2;
      if (err_cnt - e0 !== 1) begin n_fail++; $display("[TB] FAIL nack_err_count: got %0d required 1", err_cnt - e0); end
      if (done_cnt - d0 !== 0) begin n_fail++; $display("[TB] FAIL nack_done_count: got %0d required 0", done_cnt - d0); end
   endtask

   task automatic test_timeout();
      logic [9:0] bits;
      int         d0, e0, n;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'h5A);
      wait_rts();
      dev_bits(4, bits);
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      n = 0;
      while (tx_err !== 1'b1 && n < TMO + 50) begin
         @(negedge clk);
         n++;
         if (n == HALF) dev_clk_low = 1'b0;
      end
      dev_clk_low = 1'b0;
      n_checks += 3;
      if (n < TMO || n > TMO + 3) begin
         n_fail++;
         $display("[TB] FAIL timeout_latency: got %0d cycles required %0d..%0d", n, TMO, TMO + 3);
      end
      if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_clk_oe: got %b required 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL timeout_data_oe: got %b required 0", ps2_data_oe); end
      @(negedge clk);
      wait_ready();
      n_checks += 2;
      if (err_cnt - e0 !== 1) begin n_fail++; $display("[TB] FAIL timeout_err_count: got %0d required 1", err_cnt - e0); end
      if (done_cnt - d0 !== 0) begin n_fail++; $display("[TB] FAIL timeout_done_count: got %0d required 0", done_cnt - d0); end
   endtask

   task automatic test_reset_mid_frame();
      logic [9:0] bits;
      int         d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      start_tx(8'hA5);
      wait_rts();
      dev_bits(3, bits);
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (6) @(negedge clk);
      n_checks++;
      if (ps2_data_oe !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL midreset_d3_driven: got %b required 1", ps2_data_oe);
      end
      reset_ = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_clk_oe: got %b required 0", ps2_clk_oe); end
      if (ps2_data_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_data_oe: got %b required 0", ps2_data_oe); end
      if (tx_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_ready_low: got %b required 0", tx_ready); end
      reset_ = 1'b1;
      @(negedge clk);
      n_checks++;
      if (tx_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_ready: got %b required 1", tx_ready); end
      dev_clk_low = 1'b0;
      repeat (10) @(negedge clk);
      n_checks += 2;
      if (done_cnt - d0 !== 0) begin n_fail++; $display("[TB] FAIL midreset_done_count: got %0d required 0", done_cnt - d0); end
      if (err_cnt - e0 !== 0) begin n_fail++; $display("[TB] FAIL midreset_err_count: got %0d required 0", err_cnt - e0); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] bits;
      int         d0;
      d0 = done_cnt;
      start_tx(8'hF4);
      wait_rts();
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      dev_bits(10, bits);
      tx_valid = 1'b0;
      n_checks++;
      if (bits !== 10'h2F4) begin
         n_fail++;
         $display("[TB] FAIL busy_frame_bits: got %h required 2f4", bits);
      end
      dev_ack(1'b1);
      wait_ready();
      repeat (20) @(negedge clk);
      n_checks += 3;
      if (done_cnt - d0 !== 1) begin n_fail++; $display("[TB] FAIL busy_done_count: got %0d required 1", done_cnt - d0); end
      if (tx_busy !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_no_second_tx: got %b required 0", tx_busy); end
      if (ps2_clk_oe !== 1'b0) begin n_fail++; $display("[TB] FAIL busy_clk_idle: got %b required 0", ps2_clk_oe); end
   endtask

   initial begin
      $display("[TB] ps2_host_tx directed test start");
      test_reset();
      test_inhibit_rts();
      test_ack_ed();
      test_nack_ff();
      test_timeout();
      test_reset_mid_frame();
      test_back_to_back();
      n_checks++;
      if (overlap_cnt !== 0) begin
         n_fail++;
         $display("[TB] FAIL done_err_overlap: got %0d cycles required 0", overlap_cnt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
